j202_wb_arbiter: RTL

Two-master, one-slave Wishbone (classic, 32-bit) arbiter for the j202 SoC user area.
- Master 0 is the Caravel management SoC Wishbone slave path.
- Master 1 is a debug master driven from logic-analyzer bits.
- The slave is the j202 core's internal Wishbone bus.
- Round-robin grant, locked for the whole bus cycle (cyc). A bus-hang watchdog terminates stalled cycles with a fixed response word.

---
 rtl/j202_wb_pkg.sv | 31 +++
 rtl/j202_wb_watchdog.sv | 35 +++
 rtl/j202_wb_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/j202_wb_pkg.sv
// Shared types and constants for the j202 Wishbone arbiter slice.
package j202_wb_pkg;

    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [WB_DAT_W-1:0] WB_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        TOUT,
        WREL
    } arb_state_t;

    // Address is kept out of the request struct because its width is a
    // module parameter; it is muxed alongside the struct instead.
    typedef struct packed {
        logic                cyc;
        logic                stb;
        logic                we;
        logic [WB_SEL_W-1:0] sel;
        logic [WB_DAT_W-1:0] dat;
    } wb_req_t;

    typedef struct packed {
        logic                ack;
        logic [WB_DAT_W-1:0] dat;
    } wb_rsp_t;

endpackage

// File: rtl/j202_wb_watchdog.sv
// Bus-hang watchdog: counts stalled strobe cycles and fires on the
// TIMEOUT_CYC-th one. TIMEOUT_CYC of 0 disables firing entirely.
module j202_wb_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic fire
);

    localparam bit ENABLED = (TIMEOUT_CYC > 0);
    localparam int CW      = ENABLED ? $clog2(TIMEOUT_CYC + 1) : 1;

    // The stall that fires is the one that would carry the count to
    // TIMEOUT_CYC, so compare against the value one below it.
    localparam logic [CW-1:0] LAST = ENABLED ? CW'(TIMEOUT_CYC - 1) : '0;

    logic [CW-1:0] cnt;

    // Stall counter: cleared on grant entry and on every slave ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign fire = ENABLED && inc && (cnt == LAST);

endmodule

// File: rtl/j202_wb_arbiter.sv
// Two-master / one-slave classic Wishbone arbiter with round-robin grant
// locked for the whole bus cycle and a watchdog for hung slaves.
module j202_wb_arbiter
    import j202_wb_pkg::*;
#(
    parameter int          AW           = 32,
    parameter int          TIMEOUT_CYC  = 255,
    parameter logic [31:0] TIMEOUT_DATA = WB_TIMEOUT_DATA
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,

    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    input  logic [AW-1:0]       m0_adr_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    output logic                m0_ack_o,
    output logic [WB_DAT_W-1:0] m0_dat_o,

    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    input  logic [AW-1:0]       m1_adr_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    output logic                m1_ack_o,
    output logic [WB_DAT_W-1:0] m1_dat_o,

    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [WB_SEL_W-1:0] s_sel_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [WB_DAT_W-1:0] s_dat_o,
    input  logic                s_ack_i,
    input  logic [WB_DAT_W-1:0] s_dat_i,

    output logic [1:0]          gnt_o,
    output logic                timeout_o,
    input  logic                timeout_clr_i
);

    arb_state_t    state, state_nxt;
    logic [1:0]    gnt, gnt_nxt;
    logic          rr, rr_nxt;
    logic          timeout_q;

    wb_req_t       m0_req, m1_req, g_req;
    wb_rsp_t       g_rsp;
    logic [AW-1:0] g_adr;
    logic          req0, req1;
    logic          wd_clr, wd_inc, wd_fire;

    assign m0_req = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i, sel: m0_sel_i, dat: m0_dat_i};
    assign m1_req = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i, sel: m1_sel_i, dat: m1_dat_i};

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // gnt is zero in IDLE, so defaulting to m0 there is harmless: every
    // consumer below is gated by state or by a grant bit.
    assign g_req = gnt[1] ? m1_req : m0_req;
    assign g_adr = gnt[1] ? m1_adr_i : m0_adr_i;

    // State, grant and round-robin pointer registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
            gnt   <= 2'b00;
            rr    <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            rr    <= rr_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until the owner
    // drops cyc, and hand priority to the other master on every release.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        rr_nxt    = rr;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = BUSY;
                    if (req0 && req1) begin
                        gnt_nxt = rr ? 2'b10 : 2'b01;
                    end else if (req0) begin
                        gnt_nxt = 2'b01;
                    end else begin
                        gnt_nxt = 2'b10;
                    end
                end
            end
            BUSY: begin
                if (!g_req.cyc) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 2'b00;
                    rr_nxt    = gnt[0];
                end else if (wd_fire) begin
                    state_nxt = TOUT;
                end
            end
            TOUT: begin
                state_nxt = WREL;
            end
            WREL: begin
                if (!g_req.cyc) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 2'b00;
                    rr_nxt    = gnt[0];
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 2'b00;
            end
        endcase
    end

    // Output logic: pass the owner straight through in BUSY, fabricate the
    // forced response in TOUT, keep everything quiet otherwise.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        g_rsp   = '0;
        wd_clr  = 1'b0;
        wd_inc  = 1'b0;
        case (state)
            IDLE: begin
                wd_clr = req0 | req1;
            end
            BUSY: begin
                s_cyc_o   = g_req.cyc;
                s_stb_o   = g_req.stb;
                s_we_o    = g_req.we;
                s_sel_o   = g_req.sel;
                s_adr_o   = g_adr;
                s_dat_o   = g_req.dat;
                g_rsp.ack = s_ack_i;
                g_rsp.dat = s_dat_i;
                wd_clr    = s_ack_i;
                wd_inc    = g_req.cyc & g_req.stb & ~s_ack_i;
            end
            TOUT: begin
                g_rsp.ack = 1'b1;
                g_rsp.dat = TIMEOUT_DATA;
            end
            default: begin
            end
        endcase
    end

    assign m0_ack_o  = gnt[0] & g_rsp.ack;
    assign m0_dat_o  = gnt[0] ? g_rsp.dat : '0;
    assign m1_ack_o  = gnt[1] & g_rsp.ack;
    assign m1_dat_o  = gnt[1] ? g_rsp.dat : '0;
    assign gnt_o     = gnt;
    assign timeout_o = timeout_q;

    // Sticky timeout flag; a firing watchdog beats a simultaneous clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            timeout_q <= 1'b0;
        end else if (wd_fire) begin
            timeout_q <= 1'b1;
        end else if (timeout_clr_i) begin
            timeout_q <= 1'b0;
        end
    end

    j202_wb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .clr   (wd_clr),
        .inc   (wd_inc),
        .fire  (wd_fire)
    );

endmodule
